engine_arbiter: RTL and testbench

Round-robin scheduler that shares one start/done compute engine among NUM_REQ requesters. Per transaction it selects a requester, captures its operand, pulses eng_start, and waits for eng_done under a watchdog. It then returns the engine result with a one-cycle ack, or an error on timeout. It sits between the per-channel ui/ld front-ends and the single engine instance, and replaces per-channel engines.

---
 rtl/engine_arbiter_pkg.sv | 19 +
 rtl/engine_arbiter_rr_pick.sv | 35 +++
 rtl/engine_arbiter.sv | 121 ++++++++++++
 tb/tb_engine_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/engine_arbiter_pkg.sv
// Shared definitions for the engine arbiter: FSM state encoding and default
// parameter values used by the top and the round-robin picker.
package engine_arbiter_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DW_DEF      = 16;
  localparam int RW_DEF      = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4,
    S_ABORT = 3'd5
  } state_t;

endpackage

// File: rtl/engine_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after rr_ptr,
// wrapping modulo NUM_REQ; returns a one-hot select, its index and a found flag.
module engine_arbiter_rr_pick
  import engine_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] sel,
  output logic [IW-1:0]      idx,
  output logic               found
);

  logic [IW-1:0] cand;

  // NUM_REQ is a power of two, so IW-bit addition wraps for free;
  // i == NUM_REQ lands back on rr_ptr itself as the lowest priority.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = rr_ptr + IW'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    sel[idx] = found;
  end

endmodule

// File: rtl/engine_arbiter.sv
// Round-robin scheduler sharing one start/done engine among NUM_REQ requesters,
// with a watchdog on the engine response.
//
// state   | meaning
// IDLE    | no owner; pick next requester round-robin
// GRANT   | owner latched, operand presented and stable
// START   | one-cycle eng_start pulse, watchdog cleared
// WAIT    | waiting for eng_done, watchdog counting
// RESP    | ack pulse to owner, result valid on rsp_data
// ABORT   | err pulse to owner after watchdog expiry
module engine_arbiter
  import engine_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DW      = DW_DEF,
  parameter int RW      = RW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [DW-1:0]         eng_din,
  output logic                  eng_start,
  input  logic                  eng_done,
  input  logic [RW-1:0]         eng_dout,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    ack,
  output logic [NUM_REQ-1:0]    err,
  output logic [RW-1:0]         rsp_data,
  output logic                  busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [IW-1:0]     rr_ptr, owner, pick_idx;
  logic [NUM_REQ-1:0] pick_sel;
  logic              pick_found;
  logic [WW-1:0]     wd_cnt;
  logic              wd_expired;

  engine_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .sel    (pick_sel),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  assign wd_expired = (wd_cnt == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Outputs decode straight from the state register so an async reset
  // drops eng_start/ack/err/busy immediately.
  always_comb begin
    state_nxt = state;
    eng_start = 1'b0;
    ack       = '0;
    err       = '0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:  if (pick_found) state_nxt = S_GRANT;
      S_GRANT: state_nxt = S_START;
      S_START: begin
        eng_start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done)        state_nxt = S_RESP;
        else if (wd_expired) state_nxt = S_ABORT;
      end
      S_RESP: begin
        ack       = grant;
        state_nxt = S_IDLE;
      end
      S_ABORT: begin
        err       = grant;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= IW'(NUM_REQ - 1);
      owner    <= '0;
      grant    <= '0;
      eng_din  <= '0;
      rsp_data <= '0;
      wd_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            owner   <= pick_idx;
            grant   <= pick_sel;
            eng_din <= req_data[int'(pick_idx)*DW +: DW];
          end
        end
        S_START: wd_cnt <= '0;
        S_WAIT: begin
          wd_cnt <= wd_cnt + WW'(1);
          if (eng_done) rsp_data <= eng_dout;
        end
        S_RESP, S_ABORT: begin
          rr_ptr <= owner;
          grant  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_engine_arbiter.sv
// Self-checking bench for engine_arbiter: table of transactions driven through
// a cycle-accurate engine stub, responses checked against a scoreboard queue.
module tb_engine_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [63:0]     req_data;
  logic [15:0]     eng_din;
  logic            eng_start;
  logic            eng_done = 1'b0;
  logic [31:0]     eng_dout = '0;
  logic [NREQ-1:0] grant, ack, err;
  logic [31:0]     rsp_data;
  logic            busy;

  engine_arbiter #(.NUM_REQ(NREQ), .DW(16), .RW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .eng_din(eng_din), .eng_start(eng_start), .eng_done(eng_done),
    .eng_dout(eng_dout), .grant(grant), .ack(ack), .err(err),
    .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rq;
    int          dly;
    logic [31:0] res;
    int          own;
    bit          to;
    bit          drop;
  } vec_t;

  typedef struct {
    int          own;
    bit          to;
    logic [31:0] rsp;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_rsp = '0;
  logic [15:0] slice_v [NREQ];
  vec_t        vecs [10];

  assign req_data = {slice_v[3], slice_v[2], slice_v[1], slice_v[0]};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every ack/err pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && (ack != '0 || err != '0)) begin
      check("resp_onehot", 64'($onehot({ack, err})), 64'(1));
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 64'({ack, err}), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_ack", 64'(ack), mon_e.to ? 64'(0) : (64'(1) << mon_e.own));
        check("resp_err", 64'(err), mon_e.to ? (64'(1) << mon_e.own) : 64'(0));
        check("resp_data", 64'(rsp_data), 64'(mon_e.rsp));
      end
    end
  end

  // Called at a negedge with the DUT in IDLE; returns at the negedge of the
  // following IDLE cycle.
  task automatic run_txn(input vec_t v);
    int  lat;
    bit  seen;
    exp_t e;
    e.own = v.own;
    e.to  = v.to;
    e.rsp = v.to ? model_rsp : v.res;
    exp_q.push_back(e);
    if (!v.to) model_rsp = v.res;
    req = v.rq;
    @(negedge clk);
    check("grant", 64'(grant), 64'(1) << v.own);
    check("eng_din", 64'(eng_din), 64'(slice_v[v.own]));
    check("busy", 64'(busy), 64'(1));
    @(negedge clk);
    check("eng_start", 64'(eng_start), 64'(1));
    seen = 1'b0;
    lat  = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ack != '0 || err != '0) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
      if (k == 1) check("start_pulse", 64'(eng_start), 64'(0));
      eng_done = (!v.to && k == v.dly);
      eng_dout = eng_done ? v.res : 32'hDEAD_BEEF;
      if (v.drop && k == 2) req[v.own] = 1'b0;
    end
    check("resp_latency", seen ? 64'(lat) : 64'hFFFF_FFFF, 64'((v.to ? TO : v.dly) + 1));
    eng_done = 1'b0;
    req[v.own] = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_grant", 64'(grant), 64'(0));
  endtask

  initial begin
    slice_v[0] = 16'hA0A0;
    slice_v[1] = 16'h00A5;
    slice_v[2] = 16'hC2C2;
    slice_v[3] = 16'hD3D3;

    vecs[0] = '{4'b1111, 3, 32'hAAAA_0000, 0, 1'b0, 1'b0};
    vecs[1] = '{4'b1111, 1, 32'h1111_1111, 1, 1'b0, 1'b0};
    vecs[2] = '{4'b1111, 4, 32'h2222_2222, 2, 1'b0, 1'b0};
    vecs[3] = '{4'b1111, 2, 32'h3333_3333, 3, 1'b0, 1'b0};
    vecs[4] = '{4'b1111, 6, 32'h4444_4444, 0, 1'b0, 1'b0};
    vecs[5] = '{4'b0010, 5, 32'h0000_1234, 1, 1'b0, 1'b0};
    vecs[6] = '{4'b1100, 0, 32'h9999_9999, 2, 1'b1, 1'b0};
    vecs[7] = '{4'b1100, 3, 32'h7777_0003, 3, 1'b0, 1'b0};
    vecs[8] = '{4'b0001, TO, 32'h8888_0008, 0, 1'b0, 1'b0};
    vecs[9] = '{4'b0100, 4, 32'h6666_0004, 2, 1'b0, 1'b1};

    #1;
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_start", 64'(eng_start), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_din", 64'(eng_din), 64'(0));
    check("rst_rsp", 64'(rsp_data), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Dropped requester must not be re-granted; stray eng_done in IDLE is ignored.
    eng_done = 1'b1;
    eng_dout = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      eng_done = 1'b0;
      check("no_regrant_busy", 64'(busy), 64'(0));
      check("no_regrant_grant", 64'(grant), 64'(0));
    end
    check("rsp_after_stray_done", 64'(rsp_data), 64'(model_rsp));

    // Asynchronous reset in the middle of WAIT.
    req = 4'b0001;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'(1));
    #2 rst = 1'b0;
    #1;
    check("arst_grant", 64'(grant), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_start", 64'(eng_start), 64'(0));
    check("arst_ack_err", 64'({ack, err}), 64'(0));
    check("arst_rsp", 64'(rsp_data), 64'(0));
    model_rsp = '0;
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    run_txn('{4'b0001, 2, 32'h5555_6666, 0, 1'b0, 1'b0});

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
